// File: rtl/bcd_updown_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter_n
//
// Multi-digit BCD up/down counter with a built-in prescaler, a synchronous
// saturating load and per-digit active-low seven-segment decoding.
//
// The prescaler is a free-running PRESCALE_W-bit counter. Its all-ones state
// is the count tick, a one-cycle pulse every 2^PRESCALE_W clk cycles. The
// count advances only on a tick cycle with enable high. A load takes priority
// over counting and does not touch the prescaler.
//
// Parameters
//   DIGITS      number of cascaded BCD digits (1..8)
//   PRESCALE_W  prescaler width; tick period is 2^PRESCALE_W clk (1..32)
//   BLANK_LZ    1: blank leading-zero digits on the segment outputs
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   enable    in   count enable, sampled on tick cycles only
//   up_dn     in   1 = count up, 0 = count down
//   load      in   synchronous load strobe
//   load_val  in   BCD load value, digit 0 in [3:0]; nibbles > 9 load as 9
//   bcd_out   out  current count, one nibble per digit
//   seg7_out  out  active-low {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]
//   tick      out  prescaler strobe
//   tc        out  terminal-count strobe, high the cycle before a wrap
// -----------------------------------------------------------------------------
module bcd_updown_counter_n #(
  parameter int DIGITS     = 2,
  parameter int PRESCALE_W = 22,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg7_out,
  output logic                  tick,
  output logic                  tc
);

  localparam int BW = 4 * DIGITS;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a}; non-BCD codes are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // Clamp a nibble into the BCD range so the count never holds a non-digit.
  function automatic logic [3:0] sat_bcd(input logic [3:0] digit);
    logic [3:0] res;
    if (digit > 4'd9) begin
      res = 4'd9;
    end else begin
      res = digit;
    end
    return res;
  endfunction

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic [BW-1:0]         count_q;
  logic [BW-1:0]         count_d;
  logic [BW-1:0]         count_inc_s;
  logic [BW-1:0]         count_dec_s;
  logic [BW-1:0]         load_sat_s;
  logic                  tick_s;
  logic                  all_nine_s;
  logic                  all_zero_s;
  logic                  term_hit_s;

  // Prescaler next state: plain binary increment, wraps naturally.
  always_comb begin
    presc_d = presc_q + PRESCALE_W'(1'b1);
  end

  // Tick is the prescaler's last state; reset clears the prescaler so it is low.
  always_comb begin
    tick_s = &presc_q;
  end

  // Saturating load value, digit by digit.
  always_comb begin
    load_sat_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_sat_s[4*k +: 4] = sat_bcd(load_val[4*k +: 4]);
    end
  end

  // Decimal increment: a ripple carry enters digit 0; 9 wraps to 0 and
  // passes the carry on, so all-9s rolls over to all-0s.
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    carry       = 1'b1;
    count_inc_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (carry) begin
        if (digit >= 4'd9) begin
          count_inc_s[4*k +: 4] = 4'd0;
          carry                 = 1'b1;
        end else begin
          count_inc_s[4*k +: 4] = digit + 4'd1;
          carry                 = 1'b0;
        end
      end else begin
        count_inc_s[4*k +: 4] = digit;
        carry                 = 1'b0;
      end
    end
  end

  // Decimal decrement: a ripple borrow enters digit 0; 0 wraps to 9 and
  // passes the borrow on, so all-0s rolls under to all-9s.
  always_comb begin
    logic       borrow;
    logic [3:0] digit;
    borrow      = 1'b1;
    count_dec_s = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          count_dec_s[4*k +: 4] = 4'd9;
          borrow                = 1'b1;
        end else begin
          count_dec_s[4*k +: 4] = digit - 4'd1;
          borrow                = 1'b0;
        end
      end else begin
        count_dec_s[4*k +: 4] = digit;
        borrow                = 1'b0;
      end
    end
  end

  // Terminal-state detection for the carry/borrow-out strobe.
  always_comb begin
    all_nine_s = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (count_q[4*k +: 4] != 4'd9) begin
        all_nine_s = 1'b0;
      end else begin
        all_nine_s = all_nine_s;
      end
    end
    all_zero_s = (count_q == {BW{1'b0}});
  end

  // Count next state: load beats counting; otherwise count on enabled ticks.
  always_comb begin
    if (load) begin
      count_d = load_sat_s;
    end else if (tick_s && enable) begin
      if (up_dn) begin
        count_d = count_inc_s;
      end else begin
        count_d = count_dec_s;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers; reset clears both immediately, independent of clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  // Terminal count is combinational so a cascaded stage sees it in the same
  // cycle as the edge that wraps this one.
  always_comb begin
    term_hit_s = up_dn ? all_nine_s : all_zero_s;
    tc         = tick_s & enable & ~load & term_hit_s;
    tick       = tick_s;
    bcd_out    = count_q;
  end

  // Segment decode with leading-zero blanking. Walk from the top digit down,
  // tracking whether every digit seen so far is zero; digit 0 always shows.
  always_comb begin
    logic       higher_zero;
    logic [3:0] digit;
    higher_zero = 1'b1;
    seg7_out    = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit       = count_q[4*k +: 4];
      higher_zero = higher_zero & (digit == 4'd0);
      if (BLANK_LZ && (k != 0) && higher_zero) begin
        seg7_out[7*k +: 7] = 7'b1111111;
      end else begin
        seg7_out[7*k +: 7] = seg_decode(digit);
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
module tb_bcd_updown_counter_n;

  localparam int DIGITS = 2;
  localparam int PW     = 2;
  localparam int PERIOD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        up_dn;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  bcd_out;
  logic [13:0] seg7_out;
  logic        tick;
  logic        tc;

  bcd_updown_counter_n #(.DIGITS(DIGITS), .PRESCALE_W(PW), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bcd_out(bcd_out), .seg7_out(seg7_out),
    .tick(tick), .tc(tc)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: count as a plain integer 0..99, prescaler as a phase.
  int         m_val;
  int         m_pre;
  logic [7:0] last_tc_bcd;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  typedef struct {
    logic [7:0]  lv;
    logic [7:0]  exp_bcd;
    logic [13:0] exp_seg;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] exp_seg(input int v);
    logic [6:0] hi;
    logic [6:0] lo;
    lo = pat[v % 10];
    hi = (v / 10 == 0) ? 7'h7F : pat[v / 10];
    return {hi, lo};
  endfunction

  function automatic int sat_load(input logic [7:0] lv);
    int t;
    int o;
    t = int'(lv[7:4]);
    o = int'(lv[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs on the falling edge, compare, then advance the model.
  task automatic cycle(input logic ld, input logic [7:0] lv, input logic en, input logic ud);
    logic exp_tick;
    logic exp_tc;
    @(negedge clk);
    load     = ld;
    load_val = lv;
    enable   = en;
    up_dn    = ud;
    #1;
    exp_tick = (m_pre == PERIOD - 1);
    exp_tc   = exp_tick && en && !ld && (ud ? (m_val == 99) : (m_val == 0));
    check("bcd", bcd_out, to_bcd(m_val));
    check("seg", seg7_out, exp_seg(m_val));
    check("tick", tick, exp_tick);
    check("tc", tc, exp_tc);
    if (tc) last_tc_bcd = bcd_out;
    @(posedge clk);
    if (ld) m_val = sat_load(lv);
    else if (exp_tick && en) m_val = ud ? (m_val + 1) % 100 : (m_val + 99) % 100;
    m_pre = (m_pre + 1) % PERIOD;
    #1;
  endtask

  task automatic align_to(input int phase);
    for (int i = 0; i < PERIOD; i++) begin
      if (m_pre != phase) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int first;
    vecs[0] = '{8'h00, 8'h00, {7'h7F, 7'b1000000}};
    vecs[1] = '{8'h05, 8'h05, {7'h7F, 7'b0010010}};
    vecs[2] = '{8'h10, 8'h10, {7'b1111001, 7'b1000000}};
    vecs[3] = '{8'h98, 8'h98, {7'b0010000, 7'b0000000}};
    vecs[4] = '{8'hAF, 8'h99, {7'b0010000, 7'b0010000}};
    vecs[5] = '{8'h3C, 8'h39, {7'b0110000, 7'b0010000}};
    vecs[6] = '{8'h07, 8'h07, {7'h7F, 7'b1111000}};
    vecs[7] = '{8'h64, 8'h64, {7'b0000010, 7'b0011001}};

    reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    #12;
    check("rst_bcd", bcd_out, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_tc", tc, 1'b0);
    check("rst_seg", seg7_out, {7'h7F, 7'b1000000});
    #5 reset = 1'b0;
    m_val = 0; m_pre = 0;

    // Free count from reset: ten ticks in 40 clks
    repeat (40) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("up40_end", bcd_out, 8'h10);

    // Up through 99 into 00
    align_to(0);
    cycle(1'b1, 8'h98, 1'b0, 1'b1);
    last_tc_bcd = 8'hFF;
    repeat (7) cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("up_tc_at", last_tc_bcd, 8'h99);
    check("up_wrap_end", bcd_out, 8'h00);

    // Down through 00 into 99
    align_to(0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0);
    last_tc_bcd = 8'hFF;
    repeat (7) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("dn_tc_at", last_tc_bcd, 8'h00);
    check("dn_wrap_end", bcd_out, 8'h99);

    // Load on a tick cycle at 99 counting up: load wins, no tc
    align_to(0);
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    align_to(PERIOD - 1);
    cycle(1'b1, 8'h42, 1'b1, 1'b1);
    check("load_wins", bcd_out, 8'h42);

    // Enable low across ticks holds the count
    cycle(1'b1, 8'h35, 1'b0, 1'b1);
    repeat (9) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("hold_en0", bcd_out, 8'h35);

    // Load table, including saturation of non-BCD nibbles
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, vecs[i].lv, 1'b0, 1'b1);
      check("tbl_bcd", bcd_out, vecs[i].exp_bcd);
      check("tbl_seg", seg7_out, vecs[i].exp_seg);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(7) == 0), 8'($urandom), ($urandom_range(3) != 0), 1'($urandom));
    end

    // Asynchronous reset between edges at 0x57
    cycle(1'b1, 8'h57, 1'b0, 1'b1);
    check("pre_rst_bcd", bcd_out, 8'h57);
    #2 reset = 1'b1;
    #1;
    check("async_rst_bcd", bcd_out, 8'h00);
    check("async_rst_tick", tick, 1'b0);
    check("async_rst_tc", tc, 1'b0);
    check("async_rst_seg", seg7_out, {7'h7F, 7'b1000000});
    m_val = 0; m_pre = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    first = 0;
    for (int n = 1; n <= 8; n++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      if (tick) begin
        first = n;
        break;
      end
    end
    check("first_tick_edges", first, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
